// File: rtl/fifo_reader.sv
// fifo_reader: pulls words from a 1-cycle-latency FIFO into a
// 2-entry skid buffer and hands them downstream with valid/ready.
module fifo_reader #(
  parameter int DW = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          flush,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_data,
  output logic          fifo_read_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] xfer_count
);

  logic [1:0]    occ;
  logic          inflight;
  logic [DW-1:0] slot0;
  logic [DW-1:0] slot1;

  logic          pop;
  logic [2:0]    load;
  logic [1:0]    tail;
  logic [1:0]    occ_nx;
  logic [DW-1:0] s0_nx;
  logic [DW-1:0] s1_nx;

  assign out_valid = (occ != 2'd0);
  assign out_data  = slot0;
  assign pop       = out_valid & out_ready;

  // words owed to the buffer once this edge's pop is taken out
  assign load = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};

  assign fifo_read_en = rst & en & ~flush & ~fifo_empty
                      & (load < 3'd2);

  always_comb begin
    tail  = occ - {1'b0, pop};
    s0_nx = pop ? slot1 : slot0;
    s1_nx = slot1;
    if (inflight) begin
      if (tail == 2'd0) s0_nx = fifo_data;
      else              s1_nx = fifo_data;
    end
    occ_nx = tail + {1'b0, inflight};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ        <= 2'd0;
      inflight   <= 1'b0;
      slot0      <= '0;
      slot1      <= '0;
      xfer_count <= '0;
    end else begin
      slot0    <= s0_nx;
      slot1    <= s1_nx;
      occ      <= flush ? 2'd0 : occ_nx;
      inflight <= fifo_read_en;
      if (pop) xfer_count <= xfer_count + CW'(1);
    end
  end

endmodule
